// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU pipeline and a DMA/loader port.
// Define MEM_ARB_FAIRNESS_EN to enable the DMA starvation override; otherwise the CPU always has priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cpu_valid,
  input  logic                  cpu_write,
  input  logic [3:0]            cpu_wmask,
  input  logic [31:0]           cpu_wdata,
  input  logic [31:0]           cpu_addr,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_valid,
  input  logic                  dma_write,
  input  logic [3:0]            dma_wmask,
  input  logic [31:0]           dma_wdata,
  input  logic [31:0]           dma_addr,
  output logic                  dma_ready,
  output logic                  dma_rvalid,
  output logic [31:0]           dma_rdata,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  owner_t q_RdOwner;
  logic   override;
  logic   cpu_grant;
  logic   dma_grant;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] wait_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (dma_valid && !dma_grant) begin
      if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign override = (wait_cnt >= MAX_WAIT_L);
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT_L;
  assign override        = 1'b0;
`endif

  // Grants are gated by rstn so nothing reaches the memory while in reset.
  assign dma_grant = rstn && dma_valid && (!cpu_valid || override);
  assign cpu_grant = rstn && cpu_valid && !dma_grant;
  assign cpu_stall = cpu_valid && dma_grant;
  assign dma_ready = dma_grant;

  always_comb begin
    mem_valid = 1'b0;
    mem_write = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    mem_addr  = '0;
    if (cpu_grant) begin
      mem_valid = 1'b1;
      mem_write = cpu_write;
      mem_wmask = cpu_wmask;
      mem_wdata = cpu_wdata;
      mem_addr  = cpu_addr[ADDR_WIDTH+1:2];
    end else if (dma_grant) begin
      mem_valid = 1'b1;
      mem_write = dma_write;
      mem_wmask = dma_wmask;
      mem_wdata = dma_wdata;
      mem_addr  = dma_addr[ADDR_WIDTH+1:2];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_RdOwner <= OWN_NONE;
    end else if (cpu_grant && !cpu_write) begin
      q_RdOwner <= OWN_CPU;
    end else if (dma_grant && !dma_write) begin
      q_RdOwner <= OWN_DMA;
    end else begin
      q_RdOwner <= OWN_NONE;
    end
  end

  assign dma_rvalid = (q_RdOwner == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_WIDTH+2], cpu_addr[1:0],
                              dma_addr[31:ADDR_WIDTH+2], dma_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-level behavioural model.
// Follows MEM_ARB_FAIRNESS_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 14;
  localparam int unsigned MW = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_valid = 1'b0, cpu_write = 1'b0;
  logic [3:0]  cpu_wmask = '0;
  logic [31:0] cpu_wdata = '0, cpu_addr = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_valid = 1'b0, dma_write = 1'b0;
  logic [3:0]  dma_wmask = '0;
  logic [31:0] dma_wdata = '0, dma_addr = '0;
  logic        dma_ready, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_valid, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_wmask(cpu_wmask),
    .cpu_wdata(cpu_wdata), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_valid(dma_valid), .dma_write(dma_write), .dma_wmask(dma_wmask),
    .dma_wdata(dma_wdata), .dma_addr(dma_addr), .dma_ready(dma_ready),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: consecutive denied DMA cycles, and whether a DMA read returns this cycle.
  int m_waited = 0;
  bit m_pend   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_override();
`ifdef MEM_ARB_FAIRNESS_EN
    return m_waited >= int'(MW);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return (rstn === 1'b1) && (dma_valid === 1'b1) && (cpu_valid !== 1'b1 || m_override());
  endfunction

  always @(posedge clk or negedge rstn) begin : model
    bit dr;
    if (!rstn) begin
      m_waited <= 0;
      m_pend   <= 1'b0;
    end else begin
      dr = m_ready();
      m_pend <= dr && !dma_write;
      if (dma_valid && !dr) m_waited <= (m_waited < 15) ? m_waited + 1 : 15;
      else                  m_waited <= 0;
    end
  end

  always @(negedge clk) begin : cmp
    bit dr, cg;
    logic [31:0] a;
    dr = m_ready();
    cg = (rstn === 1'b1) && (cpu_valid === 1'b1) && !dr;
    chk("dma_ready", dma_ready, dr);
    chk("cpu_stall", cpu_stall, (rstn === 1'b1) && (cpu_valid === 1'b1) && dr);
    chk("mem_valid", mem_valid, cg || dr);
    chk("dma_rvalid", dma_rvalid, m_pend);
    chk("cpu_rdata", cpu_rdata, mem_rdata);
    chk("dma_rdata", dma_rdata, mem_rdata);
    if (cg || dr) begin
      a = cg ? cpu_addr : dma_addr;
      chk("mem_addr", mem_addr, (a / 4) % (32'd1 << AW));
      chk("mem_write", mem_write, cg ? cpu_write : dma_write);
      chk("mem_wmask", mem_wmask, cg ? cpu_wmask : dma_wmask);
      chk("mem_wdata", mem_wdata, cg ? cpu_wdata : dma_wdata);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
  endtask

  // Both requesters held valid; the DMA must win on exactly cycle MW+1.
  task automatic count_override(input string name);
    int first;
    first = 0;
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0200;
    dma_valid = 1'b1; dma_write = 1'b0; dma_addr = 32'h0000_0300;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (dma_ready === 1'b1) begin
        first = c;
        chk({name, "_stall"}, cpu_stall, 1'b1);
        break;
      end
      nxt();
    end
    chk(name, first, MW + 1);
    nxt();
    cpu_valid = 1'b0; dma_valid = 1'b0;
  endtask

  initial begin
    bit hold_cpu, hold_dma;
    int nready;

    // Requests asserted during reset must not reach the memory.
    cpu_valid = 1'b1; dma_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_dma_ready", dma_ready, 1'b0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    chk("rst_dma_rvalid", dma_rvalid, 1'b0);
    nxt();
    rstn = 1'b1; cpu_valid = 1'b0; dma_valid = 1'b0;

    nxt();
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0104;
    @(negedge clk);
    chk("cpu_rd_addr", mem_addr, 14'h041);
    chk("cpu_rd_valid", mem_valid, 1'b1);
    chk("cpu_rd_stall", cpu_stall, 1'b0);
    nxt();
    cpu_valid = 1'b0; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("cpu_rd_data", cpu_rdata, 32'h1234_5678);

    nxt();
    dma_valid = 1'b1; dma_write = 1'b1; dma_addr = 32'h10;
    dma_wdata = 32'hDEAD_BEEF; dma_wmask = 4'hF;
    @(negedge clk);
    chk("dma_wr_ready", dma_ready, 1'b1);
    chk("dma_wr_addr", mem_addr, 14'h004);
    chk("dma_wr_data", mem_wdata, 32'hDEAD_BEEF);
    nxt();
    dma_valid = 1'b0; dma_write = 1'b0;
    @(negedge clk);
    chk("dma_wr_no_rvalid", dma_rvalid, 1'b0);

`ifdef MEM_ARB_FAIRNESS_EN
    nxt();
    count_override("override_cycle");
`else
    nxt();
    cpu_valid = 1'b1; dma_valid = 1'b1; dma_write = 1'b0;
    nready = 0;
    repeat (100) begin
      @(negedge clk);
      if (dma_ready === 1'b1) nready++;
      nxt();
    end
    chk("strict_prio_grants", nready, 0);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("strict_prio_release", dma_ready, 1'b1);
    nxt();
    dma_valid = 1'b0;
`endif

    nxt();
    dma_valid = 1'b1; dma_write = 1'b0; dma_addr = 32'h20;
    @(negedge clk);
    chk("b2b_dma_ready", dma_ready, 1'b1);
    nxt();
    dma_valid = 1'b0; cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("b2b_rvalid", dma_rvalid, 1'b1);
    chk("b2b_rdata", dma_rdata, 32'hCAFE_F00D);
    chk("b2b_cpu_grant", mem_addr, 14'h010);
    nxt();
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rvalid_once", dma_rvalid, 1'b0);

    nxt();
    dma_valid = 1'b1; dma_write = 1'b0; dma_addr = 32'h80;
    @(negedge clk);
    chk("rst_rd_ready", dma_ready, 1'b1);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_rd_rvalid", dma_rvalid, 1'b0);
    chk("rst_rd_mem_valid", mem_valid, 1'b0);
    nxt();
    rstn = 1'b1; dma_valid = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
    nxt();
    count_override("override_after_reset");
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hold_cpu = (cpu_valid === 1'b1) && m_ready();
      hold_dma = (dma_valid === 1'b1) && !m_ready();
      nxt();
      if (!hold_cpu) begin
        cpu_valid = ($urandom_range(0, 9) < 6);
        cpu_write = $urandom_range(0, 1);
        cpu_wmask = 4'($urandom);
        cpu_wdata = $urandom;
        cpu_addr  = $urandom;
      end
      if (!hold_dma) begin
        dma_valid = ($urandom_range(0, 9) < 5);
        dma_write = $urandom_range(0, 1);
        dma_wmask = 4'($urandom);
        dma_wdata = $urandom;
        dma_addr  = $urandom;
      end
    end

    nxt();
    cpu_valid = 1'b0; dma_valid = 1'b0;
    nxt();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word-address width of the shared single-port memory.
REQ-002 SHALL have parameter MAX_WAIT, default 8, the count of consecutive denied DMA cycles that forces a DMA grant (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port cpu_valid / cpu_write / cpu_wmask / cpu_wdata / cpu_addr, input, 1/1/4/32/32, pipeline memory request.
REQ-006 SHALL have port cpu_rdata, output, 32, pipeline read data.
REQ-007 SHALL have port cpu_stall, output, 1, the CPU request is not issued this cycle.
REQ-008 SHALL have port dma_valid / dma_write / dma_wmask / dma_wdata / dma_addr, input, 1/1/4/32/32, secondary (loader/DMA) request.
REQ-009 SHALL have port dma_ready, output, 1, the DMA request is issued this cycle.
REQ-010 SHALL have port dma_rvalid / dma_rdata, output, 1/32, DMA read data, valid for one cycle.
REQ-011 SHALL have port mem_valid / mem_write / mem_wmask / mem_wdata / mem_addr, output, 1/1/4/32/ADDR_WIDTH, memory request.
REQ-012 SHALL have port mem_rdata, input, 32, memory read data; a read issued in cycle N returns its data in cycle N+1.

Function
REQ-013 SHALL grant at most one requester per cycle: the granted request drives mem_valid, mem_write, mem_wmask and mem_wdata, and mem_addr = addr[ADDR_WIDTH+1:2].
REQ-014 SHALL grant combinationally in the same cycle as the request, with zero added request latency.
REQ-015 SHALL grant the CPU whenever cpu_valid=1 and the fairness override (REQ-019) is inactive.
REQ-016 SHALL drive cpu_stall=1 exactly when cpu_valid=1 and the DMA is granted; the CPU holds its request stable while stalled.
REQ-017 SHALL drive dma_ready=1 when dma_valid=1 and either cpu_valid=0 or the override is active; the DMA holds its request until dma_ready.
REQ-018 SHALL keep mem_valid=0 when neither requester is valid.
REQ-019 SHALL keep a 4-bit wait counter with these rules: +1 each cycle dma_valid=1 and dma_ready=0; cleared on dma_ready or dma_valid=0; saturates at 15; the override is active when the counter >= MAX_WAIT.
REQ-020 SHALL register the owner of each issued read (q_RdOwner: NONE/CPU/DMA) for use in the following cycle.
REQ-021 SHALL drive cpu_rdata=mem_rdata unconditionally and dma_rdata=mem_rdata unconditionally.
REQ-022 SHALL assert dma_rvalid=1 exactly in the cycle after a granted DMA read, and never after a DMA write.
REQ-023 SHALL ignore address bits above ADDR_WIDTH+1 and bits [1:0] (no fault is generated).
REQ-024 SHALL allow back-to-back grants to alternating owners with no idle cycle; read-return routing follows q_RdOwner only.

Reset
REQ-025 SHALL, while rstn=0, set the wait counter to 0 and q_RdOwner to NONE, and hold dma_rvalid=0.
REQ-026 SHALL, when reset is asserted mid-read, discard the pending DMA return: dma_rvalid=0 in the following cycle.
REQ-027 SHALL, while rstn=0, force mem_valid=0, dma_ready=0 and cpu_stall=0 regardless of request inputs.

Configuration
REQ-028 SHALL use macro MEM_ARB_FAIRNESS_EN to select the arbitration mode.
REQ-029 SHALL, with MEM_ARB_FAIRNESS_EN defined, implement the REQ-019 starvation override.
REQ-030 SHALL, with MEM_ARB_FAIRNESS_EN undefined, omit the wait counter and use strict CPU priority, so the DMA is granted only when cpu_valid=0.

Verification
REQ-031 SHALL cover: CPU read only, cpu_addr=0x0000_0104 -> mem_addr=0x041, mem_valid=1, cpu_stall=0; next cycle cpu_rdata=mem_rdata.
REQ-032 SHALL cover: DMA write only, dma_addr=0x10, wdata=0xDEADBEEF, wmask=0xF -> dma_ready=1 in the same cycle, mem_addr=0x004, and no dma_rvalid follows.
REQ-033 SHALL cover, with FAIRNESS_EN and MAX_WAIT=8: both requesters continuously valid -> dma_ready=0 for 8 cycles, dma_ready=1 and cpu_stall=1 in the 9th cycle, counter back to 0.
REQ-034 SHALL cover, without FAIRNESS_EN: both requesters valid for 100 cycles -> dma_ready never 1; drop cpu_valid -> dma_ready=1 in the same cycle.
REQ-035 SHALL cover: DMA read granted in cycle N, then CPU read in N+1 -> dma_rvalid=1 only in N+1, carrying the DMA word.
REQ-036 SHALL cover: rstn pulled low in the cycle of a DMA read grant -> dma_rvalid=0 in the next cycle, mem_valid=0 while in reset, counter=0 after reset.
